dcache_write_buffer: RTL and testbench
======================================

// Module: dcache_write_buffer
// PURPOSE
//  Posted write buffer between the data cache memory port and the L2 arbiter port.
//  Cache writes are acked on entry and drained to L2 in order. Reads are forwarded only once the
//  buffer is empty, so a read never passes an older write.
//  up_write_outstanding tells the cache/fence logic when stores are globally visible.
// PARAMETERS
//  DEPTH  4  buffered write entries (power of 2, >=2)
// PORTS
//  clk                   in   1   clock
//  rst_n                 in   1   reset: one clock; reset is asynchronous and active-low
//  up_request            in   1   cache request valid
//  up_addr               in   30  word address [31:2]
//  up_rnw                in   1   1=read, 0=write
//  up_rlen               in   5   read burst length-1
//  up_wbe                in   4   write byte enables
//  up_wdata              in   32  write data
//  up_ack                out  1   request accepted (combinational)
//  up_rvalid, up_rdata   out  1,32  read beat to cache (passthrough)
//  up_write_outstanding  out  1   buffer non-empty | dn_write_outstanding
//  dn_request            out  1   L2 request valid
//  dn_addr, dn_rnw, dn_rlen, dn_wbe, dn_wdata  out  30,1,5,4,32  L2 request fields
//  dn_ack                in   1   L2 accepted request
//  dn_rvalid, dn_rdata   in   1,32  L2 read beat
//  dn_write_outstanding  in   1   L2 still completing writes
// BEHAVIOUR
//  Reset: count=0, ptrs=0, state IDLE; dn_request=0, up_ack=0, up_rvalid=0.
//   Reset mid-burst discards the burst.
//  Write accept: up_ack = up_request & ~up_rnw & count<DEPTH (registered count).
//   No same-cycle full bypass. Entry {addr,wbe,data} goes in at tail.
//  Read accept: up_ack = up_request & up_rnw & state==IDLE & count==0 & dn_ack.
//   dn_* is driven from up_* while IDLE with count==0.
//  FSM: IDLE, DRAIN, READ_WAIT.
//   IDLE: count>0 -> DRAIN. Else read request with dn_ack -> READ_WAIT, latch up_rlen.
//   DRAIN: dn_request=1, dn_rnw=0, head fields on dn_*.
//    On dn_ack: pop; count==1 & no push -> IDLE, else stay in DRAIN.
//   READ_WAIT: beat counter (5b) counts dn_rvalid.
//    dn_rvalid & counter==rlen -> IDLE, counter=0. No dn_request while here.
//  Writes push in any state (including READ_WAIT) when not full.
//  Same-cycle push+pop: count unchanged, both pointers advance; pointers wrap mod DEPTH.
//  up_rvalid/up_rdata = dn_rvalid/dn_rdata, zero latency.
//   dn_rvalid outside READ_WAIT is ignored and counted as a protocol error.
//  Writes never reorder; a read waits until every older write is acked by L2.
// CONFIGURATION
//  WRITE_MERGE_EN defined:
//   Write to same up_addr as tail entry, where tail != head-under-DRAIN, merges.
//   Per-byte data replace where up_wbe set; wbe |= up_wbe.
//   Acked same cycle even when full; count unchanged.
//  Undefined: every write allocates a new entry.
// STRUCTURE
//  cva5_types: wb_entry_t {logic[29:0] addr; logic[3:0] be; logic[31:0] data}, wb_state_t enum.
//  Sub-module dcache_wb_fifo: circular buffer of wb_entry_t with DEPTH, push/pop, count, full/empty.
//   Exposes tail entry and tail write port for merging.
// TESTING
//  1 Write 0x100/0xDEADBEEF/be=F, dn_ack held 0 -> up_ack=1 same cycle;
//    dn_request=1 next cycle, dn_wdata=0xDEADBEEF; up_write_outstanding=1.
//  2 Five writes with dn_ack=0, DEPTH=4 -> first four acked, fifth held with up_ack=0 until first dn_ack.
//  3 Two writes queued, then read 0x200 rlen=3 -> read unacked until both writes drain;
//    four up_rvalid beats, then IDLE.
//  4 Push+pop same cycle at count=DEPTH-1, 200 random cycles -> L2 write order equals accept order
//    (scoreboard), no loss across wrap.
//  5 WRITE_MERGE_EN: writes 0x300 be=0x3 data=0x1111, then 0x300 be=0xC data=0x22220000 while draining an older entry
//    -> single L2 write be=F data=0x22221111.
//  6 rst_n low during DRAIN with 3 entries -> dn_request=0 immediately; up_write_outstanding=0
//    once dn_write_outstanding=0.

Source files
------------

// File: rtl/dcache_write_buffer_pkg.sv
// dcache_write_buffer_pkg: shared types and helpers for the posted write buffer.
package dcache_write_buffer_pkg;
    localparam int WB_DEPTH = 4;
    typedef struct packed {
        logic [29:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } wb_entry_t;
    typedef enum logic [1:0] {IDLE, DRAIN, READ_WAIT} wb_state_t;
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_data, input logic [31:0] new_data,
                                                input logic [3:0] be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) res[8*i +: 8] = be[i] ? new_data[8*i +: 8] : old_data[8*i +: 8];
        return res;
    endfunction
endpackage

// File: rtl/dcache_write_buffer_if.sv
// dcache_write_buffer_if: cache-style request/read-beat bus, used for both the cache and L2 sides.
interface dcache_write_buffer_if;
    logic        request;
    logic [29:0] addr;
    logic        rnw;
    logic [4:0]  rlen;
    logic [3:0]  wbe;
    logic [31:0] wdata;
    logic        ack;
    logic        rvalid;
    logic [31:0] rdata;
    logic        write_outstanding;
    modport master(output request, addr, rnw, rlen, wbe, wdata,
                   input ack, rvalid, rdata, write_outstanding);
    modport slave(input request, addr, rnw, rlen, wbe, wdata,
                  output ack, rvalid, rdata, write_outstanding);
endinterface

// File: rtl/dcache_wb_fifo.sv
// dcache_wb_fifo: circular buffer of write entries with an in-place merge port on the tail entry.
module dcache_wb_fifo
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     merge,
    input  wb_entry_t                din,
    output wb_entry_t                head,
    output wb_entry_t                tail_entry,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr, last;
    assign last       = wr_ptr - AW'(1);
    assign head       = mem[rd_ptr];
    assign tail_entry = mem[last];
    assign full       = count == (AW+1)'(DEPTH);
    assign empty      = count == '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= rd_ptr + AW'(pop);
            wr_ptr <= wr_ptr + AW'(push);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // push and merge are mutually exclusive; merge rewrites the most recently pushed entry
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
        else if (merge) mem[last] <= {mem[last].addr, mem[last].be | din.be,
                                      merge_bytes(mem[last].data, din.data, din.be)};
    end
endmodule

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer: posted, in-order write buffer between the data cache and the L2 arbiter.
// Define WRITE_MERGE_EN to merge a write into the tail entry when it hits the same word.
module dcache_write_buffer
    import dcache_write_buffer_pkg::*;
#(
    parameter int DEPTH = WB_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dcache_write_buffer_if.slave   up,
    dcache_write_buffer_if.master  dn,
    output logic [7:0]             proto_err_count
);
    localparam int CW = $clog2(DEPTH) + 1;
`ifdef WRITE_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif
    wb_state_t state, next_state;
    logic [4:0] rlen, beat;
    logic wr, rd, push, pop, merge, full, empty;
    logic [CW-1:0] count;
    wb_entry_t head, tail_entry;
    assign wr    = up.request & ~up.rnw;
    assign rd    = up.request & up.rnw;
    // the head entry is frozen while it is presented to L2, so never merge into it then
    assign merge = MERGE & wr & ~empty & (up.addr == tail_entry.addr) & ~(state == DRAIN & count == CW'(1));
    assign push  = wr & ~merge & ~full;
    assign pop   = (state == DRAIN) & dn.ack;
    assign up.ack = wr ? (merge | ~full) : (rd & state == IDLE & empty & dn.ack);
    assign up.rvalid = dn.rvalid & (state == READ_WAIT);
    assign up.rdata  = dn.rdata;
    assign up.write_outstanding = ~empty | dn.write_outstanding;
    dcache_wb_fifo #(.DEPTH(DEPTH)) fifo (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .merge(merge),
        .din('{addr: up.addr, be: up.wbe, data: up.wdata}),
        .head(head), .tail_entry(tail_entry), .count(count), .full(full), .empty(empty)
    );
    always_comb begin
        next_state = state;
        dn.request = 1'b0;
        dn.addr    = '0;
        dn.rnw     = 1'b0;
        dn.rlen    = '0;
        dn.wbe     = '0;
        dn.wdata   = '0;
        if (state == IDLE) begin
            if (!empty || push) next_state = DRAIN;
            else if (rd && dn.ack) next_state = READ_WAIT;
            // only reads pass straight through; writes always go via the buffer
            if (empty) begin
                dn.request = rd;
                dn.addr    = up.addr;
                dn.rnw     = up.rnw;
                dn.rlen    = up.rlen;
                dn.wbe     = up.wbe;
                dn.wdata   = up.wdata;
            end
        end else if (state == DRAIN) begin
            dn.request = 1'b1;
            dn.addr    = head.addr;
            dn.wbe     = head.be;
            dn.wdata   = head.data;
            if (pop && count == CW'(1) && !push) next_state = IDLE;
        end else if (dn.rvalid && beat == rlen) next_state = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rlen            <= '0;
            beat            <= '0;
            proto_err_count <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == READ_WAIT) rlen <= up.rlen;
            if (state == READ_WAIT && dn.rvalid) beat <= (beat == rlen) ? '0 : beat + 5'd1;
            if (state != READ_WAIT && dn.rvalid) proto_err_count <= proto_err_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer: directed checks of the posted write buffer (merge case under WRITE_MERGE_EN).
module tb_dcache_write_buffer;
    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] proto_err_count;
    int total = 0;
    int bad = 0;
    logic [65:0] q[$];
    int n = 0;
    dcache_write_buffer_if up_bus();
    dcache_write_buffer_if dn_bus();
    dcache_write_buffer dut (.clk(clk), .rst_n(rst_n), .up(up_bus), .dn(dn_bus), .proto_err_count(proto_err_count));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr_set(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        up_bus.request = 1'b1;
        up_bus.rnw     = 1'b0;
        up_bus.addr    = a;
        up_bus.wdata   = d;
        up_bus.wbe     = be;
    endtask
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end
    initial begin
        rst_n = 1'b0;
        up_bus.request = 0; up_bus.addr = 0; up_bus.rnw = 0; up_bus.rlen = 0; up_bus.wbe = 0; up_bus.wdata = 0;
        dn_bus.ack = 0; dn_bus.rvalid = 0; dn_bus.rdata = 0; dn_bus.write_outstanding = 0;
        #1;
        chk("rst_dn_req", dn_bus.request, 0);
        chk("rst_up_ack", up_bus.ack, 0);
        chk("rst_rvalid", up_bus.rvalid, 0);
        chk("rst_wo", up_bus.write_outstanding, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        // 1: single write, acked on entry, drained next cycle
        wr_set(30'h100, 32'hDEADBEEF, 4'hF);
        #1;
        chk("t1_ack", up_bus.ack, 1);
        chk("t1_no_bypass", dn_bus.request, 0);
        tick();
        up_bus.request = 0;
        #1;
        chk("t1_dn_req", dn_bus.request, 1);
        chk("t1_dn_rnw", dn_bus.rnw, 0);
        chk("t1_dn_addr", dn_bus.addr, 30'h100);
        chk("t1_dn_wdata", dn_bus.wdata, 32'hDEADBEEF);
        chk("t1_wo", up_bus.write_outstanding, 1);
        dn_bus.ack = 1;
        tick();
        dn_bus.ack = 0;
        #1;
        chk("t1_idle_req", dn_bus.request, 0);
        chk("t1_wo_clear", up_bus.write_outstanding, 0);
        // 2: fill to DEPTH, fifth write held until a slot frees
        for (int i = 0; i < 4; i++) begin
            wr_set(30'h10 + 30'(i), 32'(i), 4'hF);
            #1;
            chk("t2_ack", up_bus.ack, 1);
            tick();
        end
        wr_set(30'h14, 32'h4, 4'hF);
        #1;
        chk("t2_full", up_bus.ack, 0);
        tick();
        #1;
        chk("t2_full_hold", up_bus.ack, 0);
        dn_bus.ack = 1;
        #1;
        chk("t2_full_pop_cycle", up_bus.ack, 0);
        chk("t2_head0", dn_bus.addr, 30'h10);
        tick();
        dn_bus.ack = 0;
        #1;
        chk("t2_fifth_ack", up_bus.ack, 1);
        tick();
        up_bus.request = 0;
        dn_bus.ack = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t2_drain_req", dn_bus.request, 1);
            chk("t2_drain_addr", dn_bus.addr, 30'h11 + 30'(k));
            chk("t2_drain_data", dn_bus.wdata, 32'(k + 1));
            tick();
        end
        dn_bus.ack = 0;
        #1;
        chk("t2_empty_wo", up_bus.write_outstanding, 0);
        chk("t2_empty_req", dn_bus.request, 0);
        // 3: read waits behind two queued writes, then four beats
        wr_set(30'h20, 32'hA, 4'hF); tick();
        wr_set(30'h21, 32'hB, 4'hF); tick();
        up_bus.request = 1; up_bus.rnw = 1; up_bus.addr = 30'h200; up_bus.rlen = 5'd3;
        dn_bus.ack = 1;
        #1;
        chk("t3_rd_block0", up_bus.ack, 0);
        chk("t3_w0_addr", dn_bus.addr, 30'h20);
        chk("t3_w0_rnw", dn_bus.rnw, 0);
        tick();
        #1;
        chk("t3_rd_block1", up_bus.ack, 0);
        chk("t3_w1_addr", dn_bus.addr, 30'h21);
        tick();
        #1;
        chk("t3_rd_ack", up_bus.ack, 1);
        chk("t3_rd_req", dn_bus.request, 1);
        chk("t3_rd_rnw", dn_bus.rnw, 1);
        chk("t3_rd_addr", dn_bus.addr, 30'h200);
        chk("t3_rd_rlen", dn_bus.rlen, 5'd3);
        tick();
        up_bus.request = 0; dn_bus.ack = 0;
        #1;
        chk("t3_wait_noreq", dn_bus.request, 0);
        for (int b = 0; b < 4; b++) begin
            dn_bus.rvalid = 1; dn_bus.rdata = 32'hA0 + 32'(b);
            #1;
            chk("t3_beat_valid", up_bus.rvalid, 1);
            chk("t3_beat_data", up_bus.rdata, 32'hA0 + 32'(b));
            tick();
        end
        dn_bus.rdata = 32'hBAD;
        #1;
        chk("t3_idle_stray", up_bus.rvalid, 0);
        tick();
        dn_bus.rvalid = 0;
        #1;
        chk("t3_proto_err", proto_err_count, 1);
        // 4: random accept/drain traffic against an in-order scoreboard
        for (int c = 0; c < 200; c++) begin
            wr_set(30'h1000 + 30'(n), $urandom, 4'($urandom_range(1, 15)));
            up_bus.request = ($urandom_range(0, 9) < 7);
            dn_bus.ack = 1'($urandom_range(0, 1));
            #1;
            chk("t4_ack", up_bus.ack, up_bus.request && q.size() < 4);
            if (dn_bus.request && dn_bus.ack) begin
                chk("t4_nonempty", q.size() > 0, 1);
                if (q.size() > 0) begin
                    chk("t4_order", {dn_bus.addr, dn_bus.wbe, dn_bus.wdata}, q[0]);
                    void'(q.pop_front());
                end
            end
            if (up_bus.ack) begin
                q.push_back({up_bus.addr, up_bus.wbe, up_bus.wdata});
                n++;
            end
            tick();
        end
        up_bus.request = 0;
        dn_bus.ack = 1;
        for (int k = 0; k < 10 && q.size() > 0; k++) begin
            #1;
            if (dn_bus.request) begin
                chk("t4_tail_order", {dn_bus.addr, dn_bus.wbe, dn_bus.wdata}, q[0]);
                void'(q.pop_front());
            end
            tick();
        end
        dn_bus.ack = 0;
        #1;
        chk("t4_left", q.size(), 0);
        chk("t4_wo", up_bus.write_outstanding, 0);
`ifdef WRITE_MERGE_EN
        // 5: second write to the tail word merges while an older entry drains
        wr_set(30'h400, 32'h5, 4'hF); tick();
        wr_set(30'h300, 32'h1111, 4'h3); tick();
        wr_set(30'h300, 32'h22220000, 4'hC);
        #1;
        chk("t5_merge_ack", up_bus.ack, 1);
        tick();
        up_bus.request = 0;
        dn_bus.ack = 1;
        #1;
        chk("t5_old_addr", dn_bus.addr, 30'h400);
        tick();
        #1;
        chk("t5_m_addr", dn_bus.addr, 30'h300);
        chk("t5_m_be", dn_bus.wbe, 4'hF);
        chk("t5_m_data", dn_bus.wdata, 32'h22221111);
        tick();
        dn_bus.ack = 0;
        #1;
        chk("t5_single", up_bus.write_outstanding, 0);
`endif
        // 6: asynchronous reset while draining
        wr_set(30'h50, 32'h1, 4'hF); tick();
        wr_set(30'h51, 32'h2, 4'hF); tick();
        wr_set(30'h52, 32'h3, 4'hF); tick();
        up_bus.request = 0;
        #1;
        chk("t6_draining", dn_bus.request, 1);
        dn_bus.write_outstanding = 1;
        #2;
        rst_n = 0;
        #1;
        chk("t6_rst_req", dn_bus.request, 0);
        chk("t6_rst_wo_dn", up_bus.write_outstanding, 1);
        dn_bus.write_outstanding = 0;
        #1;
        chk("t6_rst_wo", up_bus.write_outstanding, 0);
        tick();
        rst_n = 1;
        tick();
        #1;
        chk("t6_after_req", dn_bus.request, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
